// File: rtl/snail_cpu.sv
// snail_cpu: 8-bit single-cycle Harvard core with a 16x8 register file.
// One 24-bit instruction is fetched from rom_addr = PC and committed at each posedge.
module snail_cpu (
    input  logic        clk,
    input  logic        rst_,
    output logic [7:0]  rom_addr,
    input  logic [23:0] rom_data,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_wdat,
    input  logic [7:0]  ram_rdat,
    output logic        ram_rd_,
    output logic        ram_wr_
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
        OP_ADD  = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
        OP_XOR  = 4'h8, OP_SHL = 4'h9, OP_SHR = 4'hA, OP_ADDI = 4'hB,
        OP_JMP  = 4'hC, OP_JZ  = 4'hD, OP_JNZ = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    logic [7:0] pc_q, pc_d;
    logic       halted_q, halted_d;
    logic [7:0] regs_q [16];

    logic       rf_we;
    logic [3:0] rf_waddr;
    logic [7:0] rf_wdata;

    opcode_e    op;
    logic [3:0] rd, ra, rb;
    logic [7:0] imm;
    logic [7:0] rd_val, ra_val, rb_val;
    logic [3:0] unused_rsvd;

    assign op          = opcode_e'(rom_data[23:20]);
    assign rd          = rom_data[19:16];
    assign ra          = rom_data[11:8];
    assign rb          = rom_data[3:0];
    assign imm         = rom_data[7:0];
    assign unused_rsvd = rom_data[15:12];

    // Combinational reads see the pre-commit value, so a same-cycle read-after-write gets the old data.
    assign rd_val   = regs_q[rd];
    assign ra_val   = regs_q[ra];
    assign rb_val   = regs_q[rb];
    assign rom_addr = pc_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        pc_d     = pc_q + 8'd1;
        halted_d = halted_q;
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = 8'h00;
        ram_addr = 8'h00;
        ram_wdat = 8'h00;
        ram_rd_  = 1'b1;
        ram_wr_  = 1'b1;

        if (halted_q) begin
            pc_d = pc_q;
        end else begin
            case (op)
                OP_NOP:  ;
                OP_LDI:  begin rf_we = 1'b1; rf_wdata = imm; end
                OP_LD:   begin
                    rf_we    = 1'b1;
                    rf_wdata = ram_rdat;
                    ram_rd_  = 1'b0;
                    ram_addr = imm;
                end
                OP_ST:   begin
                    ram_wr_  = 1'b0;
                    ram_addr = imm;
                    ram_wdat = rd_val;
                end
                OP_ADD:  begin rf_we = 1'b1; rf_wdata = ra_val + rb_val; end
                OP_SUB:  begin rf_we = 1'b1; rf_wdata = ra_val - rb_val; end
                OP_AND:  begin rf_we = 1'b1; rf_wdata = ra_val & rb_val; end
                OP_OR:   begin rf_we = 1'b1; rf_wdata = ra_val | rb_val; end
                OP_XOR:  begin rf_we = 1'b1; rf_wdata = ra_val ^ rb_val; end
                OP_SHL:  begin rf_we = 1'b1; rf_wdata = {ra_val[6:0], 1'b0}; end
                OP_SHR:  begin rf_we = 1'b1; rf_wdata = {1'b0, ra_val[7:1]}; end
                OP_ADDI: begin rf_we = 1'b1; rf_wdata = ra_val + imm; end
                OP_JMP:  pc_d = imm;
                OP_JZ:   if (ra_val == 8'h00) pc_d = imm;
                OP_JNZ:  if (ra_val != 8'h00) pc_d = imm;
                OP_HLT:  begin pc_d = pc_q; halted_d = 1'b1; end
                default: ;
            endcase
        end

        // Reset squashes whatever the current instruction would write or strobe.
        if (rst_) begin
            rf_we    = 1'b0;
            ram_addr = 8'h00;
            ram_wdat = 8'h00;
            ram_rd_  = 1'b1;
            ram_wr_  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_) begin
            pc_q     <= 8'h00;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: this array is reset only because the architecture defines every register as zero after reset.
        if (rst_) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_snail_cpu.sv
// Bench for snail_cpu: ROM/RAM models, directed programs, and a RAM-write scoreboard
// whose monitor compares every observed store against the queued expectation.
module tb_snail_cpu;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdat;
    logic [7:0]  ram_rdat;
    logic        ram_rd_;
    logic        ram_wr_;

    logic [23:0] rom [256];
    logic [7:0]  ram [256];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q [$];

    int n_total = 0;
    int n_pass  = 0;

    snail_cpu dut (
        .clk      (clk),
        .rst_     (rst_),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .ram_addr (ram_addr),
        .ram_wdat (ram_wdat),
        .ram_rdat (ram_rdat),
        .ram_rd_  (ram_rd_),
        .ram_wr_  (ram_wr_)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];
    assign ram_rdat = ram[ram_addr];

    always @(posedge clk) begin
        if (ram_wr_ === 1'b0) ram[ram_addr] <= ram_wdat;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: strobe exclusivity every cycle, and every store matched against the scoreboard.
    always @(negedge clk) begin
        check("strobe_excl", {31'b0, ram_rd_ | ram_wr_}, 32'd1);
        if (ram_wr_ === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: addr %0h data %0h with no store expected", ram_addr, ram_wdat);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {24'b0, ram_addr}, {24'b0, e.addr});
                check("wr_data", {24'b0, ram_wdat}, {24'b0, e.data});
            end
        end
    end

    function automatic logic [23:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic [7:0] lo);
        return {op, rd, 4'h0, ra, lo};
    endfunction

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 24'hF00000;
    endtask

    // Called while rst_ is already high; one reset edge, then release with PC at 0.
    task automatic do_reset();
        rst_ = 1'b1;
        tick(1);
        rst_ = 1'b0;
        #1;
        check("reset_pc", {24'b0, rom_addr}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        clear_rom();
        tick(1);

        // Character output: 'A' to RAM[0], then halt at PC 2.
        rst_ = 1'b1;
        clear_rom();
        rom[0] = enc(4'h1, 4'h1, 4'h0, 8'h41);
        rom[1] = enc(4'h3, 4'h1, 4'h0, 8'h00);
        rom[2] = enc(4'hF, 4'h0, 4'h0, 8'h00);
        push_wr(8'h00, 8'h41);
        do_reset();
        tick(5);
        check("hlt_pc", {24'b0, rom_addr}, 32'h2);
        check("hlt_no_wr", {31'b0, ram_wr_}, 32'h1);
        check("ram0_A", {24'b0, ram[0]}, 32'h41);

        // Modulo-256 wrap on ADDI and SUB.
        rst_ = 1'b1;
        clear_rom();
        rom[0] = enc(4'h1, 4'h2, 4'h0, 8'hFF);
        rom[1] = enc(4'hB, 4'h3, 4'h2, 8'h02);
        rom[2] = enc(4'h5, 4'h4, 4'h0, 8'h02);
        rom[3] = enc(4'h3, 4'h3, 4'h0, 8'h01);
        rom[4] = enc(4'h3, 4'h4, 4'h0, 8'h02);
        push_wr(8'h01, 8'h01);
        push_wr(8'h02, 8'h01);
        do_reset();
        tick(8);

        // Countdown loop: 3 iterations, HLT reached after 8 edges.
        rst_ = 1'b1;
        clear_rom();
        ram[5] = 8'hEE;
        rom[0] = enc(4'h1, 4'h1, 4'h0, 8'h03);
        rom[1] = enc(4'hB, 4'h1, 4'h1, 8'hFF);
        rom[2] = enc(4'hE, 4'h0, 4'h1, 8'h01);
        rom[3] = enc(4'h3, 4'h1, 4'h0, 8'h05);
        push_wr(8'h05, 8'h00);
        do_reset();
        n = 0;
        while (rom_addr !== 8'h04 && n < 50) begin
            tick(1);
            n++;
        end
        check("loop_cycles", n, 32'd8);
        tick(2);
        check("ram5_zero", {24'b0, ram[5]}, 32'h0);

        // Load, XOR-to-zero, taken JZ; the fall-through store must never happen.
        rst_ = 1'b1;
        clear_rom();
        ram[7] = 8'h5A;
        rom[0]     = enc(4'h2, 4'h5, 4'h0, 8'h07);
        rom[1]     = enc(4'h8, 4'h6, 4'h5, 8'h05);
        rom[2]     = enc(4'hD, 4'h0, 4'h6, 8'h10);
        rom[3]     = enc(4'h3, 4'h5, 4'h0, 8'h30);
        rom[8'h10] = enc(4'h3, 4'h5, 4'h0, 8'h08);
        rom[8'h11] = enc(4'h3, 4'h6, 4'h0, 8'h09);
        push_wr(8'h08, 8'h5A);
        push_wr(8'h09, 8'h00);
        do_reset();
        check("ld_rd_strobe", {31'b0, ram_rd_}, 32'h0);
        check("ld_addr", {24'b0, ram_addr}, 32'h07);
        tick(3);
        check("jz_target", {24'b0, rom_addr}, 32'h10);
        tick(4);

        // ALU coverage plus not-taken JZ/JNZ and an unconditional JMP.
        rst_ = 1'b1;
        clear_rom();
        rom[0]     = enc(4'h1, 4'h1, 4'h0, 8'hC3);
        rom[1]     = enc(4'h1, 4'h2, 4'h0, 8'h5A);
        rom[2]     = enc(4'h4, 4'h3, 4'h1, 8'h02);
        rom[3]     = enc(4'h6, 4'h4, 4'h1, 8'h02);
        rom[4]     = enc(4'h7, 4'h5, 4'h1, 8'h02);
        rom[5]     = enc(4'h9, 4'h6, 4'h1, 8'h00);
        rom[6]     = enc(4'hA, 4'h7, 4'h1, 8'h00);
        rom[7]     = enc(4'h3, 4'h3, 4'h0, 8'h40);
        rom[8]     = enc(4'h3, 4'h4, 4'h0, 8'h41);
        rom[9]     = enc(4'h3, 4'h5, 4'h0, 8'h42);
        rom[10]    = enc(4'h3, 4'h6, 4'h0, 8'h43);
        rom[11]    = enc(4'h3, 4'h7, 4'h0, 8'h44);
        rom[12]    = enc(4'hD, 4'h0, 4'h1, 8'h80);
        rom[13]    = enc(4'hE, 4'h0, 4'h0, 8'h80);
        rom[14]    = enc(4'hC, 4'h0, 4'h0, 8'h20);
        rom[15]    = enc(4'h3, 4'h1, 4'h0, 8'h4F);
        rom[8'h20] = enc(4'h3, 4'h2, 4'h0, 8'h45);
        rom[8'h80] = enc(4'h3, 4'h1, 4'h0, 8'h4E);
        push_wr(8'h40, 8'h1D);
        push_wr(8'h41, 8'h42);
        push_wr(8'h42, 8'hDB);
        push_wr(8'h43, 8'h86);
        push_wr(8'h44, 8'h61);
        push_wr(8'h45, 8'h5A);
        do_reset();
        tick(20);
        check("alu_hlt_pc", {24'b0, rom_addr}, 32'h21);

        // PC wraps from 0xFF to 0x00.
        rst_ = 1'b1;
        clear_rom();
        rom[0]     = enc(4'hC, 4'h0, 4'h0, 8'hFF);
        rom[8'hFF] = enc(4'h0, 4'h0, 4'h0, 8'h00);
        do_reset();
        tick(1);
        check("pc_jmp_ff", {24'b0, rom_addr}, 32'hFF);
        tick(1);
        check("pc_wrap", {24'b0, rom_addr}, 32'h00);

        // Reset asserted during a store cycle: no write, PC back to 0.
        rst_ = 1'b1;
        clear_rom();
        ram[8'h50] = 8'h11;
        rom[0] = enc(4'h1, 4'h1, 4'h0, 8'h77);
        rom[1] = enc(4'h3, 4'h1, 4'h0, 8'h50);
        do_reset();
        tick(1);
        check("st_cycle_pc", {24'b0, rom_addr}, 32'h1);
        rst_ = 1'b1;
        #1;
        check("rst_wr_gate", {31'b0, ram_wr_}, 32'h1);
        check("rst_addr", {24'b0, ram_addr}, 32'h0);
        check("rst_wdat", {24'b0, ram_wdat}, 32'h0);
        tick(1);
        check("rst_pc", {24'b0, rom_addr}, 32'h0);
        check("ram50_kept", {24'b0, ram[8'h50]}, 32'h11);
        push_wr(8'h50, 8'h77);
        rst_ = 1'b0;
        tick(4);

        // Reset clears every register, including ones dirtied by earlier programs.
        rst_ = 1'b1;
        clear_rom();
        rom[0] = enc(4'h3, 4'h1, 4'h0, 8'h60);
        rom[1] = enc(4'h3, 4'h2, 4'h0, 8'h61);
        rom[2] = enc(4'h3, 4'h5, 4'h0, 8'h62);
        rom[3] = enc(4'h3, 4'h7, 4'h0, 8'h63);
        rom[4] = enc(4'h3, 4'hF, 4'h0, 8'h64);
        for (int i = 0; i < 5; i++) push_wr(8'h60 + 8'(i), 8'h00);
        do_reset();
        tick(8);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
